// File: rtl/piso_pkg.sv
// Shared types for the PISO serializer: FSM state encoding and counter sizing.
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    // The counter must hold values 0..width, because it steps past the last bit.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/piso_serializer.sv
// MSB-first parallel-in serial-out transmitter with valid/ready load and gapless frames.
// Optional trailing even-parity bit when PISO_PARITY_EN is defined.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pi,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             so,
    output logic             so_valid,
    output logic             so_last,
    output logic             busy
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] shreg_reg, shreg_next;
    logic [CW-1:0]    count_reg, count_next;
    logic             accept;
    logic             last_bit;

    assign accept   = load_valid && load_ready;
    assign last_bit = (state_reg == SHIFT) && (count_reg == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            shreg_reg <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            shreg_reg <= shreg_next;
            count_reg <= count_next;
        end
    end

`ifdef PISO_PARITY_EN
    logic parity_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_reg <= 1'b0;
        end else if (accept) begin
            parity_reg <= ^pi;
        end
    end
`endif

    always_comb begin
        state_next = state_reg;
        shreg_next = shreg_reg;
        count_next = count_reg;
        case (state_reg)
            IDLE: begin
                state_next = IDLE;
            end
            SHIFT: begin
                shreg_next = {shreg_reg[WIDTH-2:0], 1'b0};
                count_next = count_reg + CW'(1);
                if (last_bit) begin
`ifdef PISO_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = IDLE;
`endif
                end
            end
            PARITY: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // A new word overrides whatever the current frame would do next,
        // which is what makes back-to-back frames contiguous.
        if (accept) begin
            shreg_next = pi;
            count_next = '0;
            state_next = SHIFT;
        end
    end

    always_comb begin
        load_ready = 1'b0;
        so         = 1'b0;
        so_valid   = 1'b0;
        so_last    = 1'b0;
        case (state_reg)
            IDLE: begin
                load_ready = 1'b1;
            end
            SHIFT: begin
                so       = shreg_reg[WIDTH-1];
                so_valid = 1'b1;
`ifndef PISO_PARITY_EN
                load_ready = last_bit;
                so_last    = last_bit;
`endif
            end
            PARITY: begin
`ifdef PISO_PARITY_EN
                load_ready = 1'b1;
                so         = parity_reg;
                so_valid   = 1'b1;
                so_last    = 1'b1;
`endif
            end
            default: begin
                load_ready = 1'b0;
            end
        endcase
        busy = so_valid;
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: directed scenarios plus random traffic
// against a bit-queue reference model and a SIPO-style receiver.
module tb_piso_serializer;

    localparam int W = 4;
`ifdef PISO_PARITY_EN
    localparam int FL  = W + 1;
    localparam bit PAR = 1'b1;
`else
    localparam int FL  = W;
    localparam bit PAR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] pi = '0;
    logic         load_valid = 1'b0;
    logic         load_ready, so, so_valid, so_last, busy;

    piso_serializer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .pi         (pi),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .so         (so),
        .so_valid   (so_valid),
        .so_last    (so_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Each entry is {last, bit} for one expected serial cycle.
    logic [1:0]   exp_q[$];
    logic [W-1:0] word_q[$];
    logic [W-1:0] rx_reg = '0;
    logic [W-1:0] rx_last = '0;
    int           rx_cnt = 0;
    int           n_cmp = 0;
    int           n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [W-1:0] d);
        for (int k = W - 1; k >= 0; k--) begin
            exp_q.push_back({(!PAR && k == 0), d[k]});
        end
        if (PAR) exp_q.push_back({1'b1, ^d});
        word_q.push_back(d);
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance model at the edge.
    task automatic step(input logic v, input logic [W-1:0] d, input logic r);
        logic m_ready, o_so, o_valid, o_last;
        load_valid = v;
        pi         = d;
        rst        = r;
        @(negedge clk);
        m_ready = (exp_q.size() <= 1);
        chk("load_ready", load_ready, m_ready);
        if (exp_q.size() == 0) begin
            chk("so_idle", so, 1'b0);
            chk("so_valid", so_valid, 1'b0);
            chk("so_last", so_last, 1'b0);
            chk("busy", busy, 1'b0);
        end else begin
            chk("so", so, exp_q[0][0]);
            chk("so_valid", so_valid, 1'b1);
            chk("so_last", so_last, exp_q[0][1]);
            chk("busy", busy, 1'b1);
        end
        o_so    = so;
        o_valid = so_valid;
        o_last  = so_last;
        @(posedge clk);
        if (r) begin
            exp_q.delete();
            word_q.delete();
            rx_cnt = 0;
        end else begin
            if (o_valid) begin
                if (rx_cnt < W) rx_reg = {rx_reg[W-2:0], o_so};
                rx_cnt++;
                if (o_last) begin
                    rx_last = rx_reg;
                    rx_cnt  = 0;
                    if (word_q.size() > 0) begin
                        chk("rx_word", rx_reg, word_q.pop_front());
                        $display("rx  word=%h", rx_reg);
                    end else begin
                        chk("rx_spurious_last", o_last, 1'b0);
                    end
                end
            end
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (v && m_ready) begin
                push_frame(d);
                $display("load word=%h", d);
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        // Reset held, then idle outputs
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        idle(2);

        // Loopback single frame
        step(1'b1, 4'b1011, 1'b0);
        idle(FL + 1);
        chk("loop_po", rx_last, 4'b1011);

        // Back-to-back: second word held until accepted on the final cycle
        step(1'b1, 4'b1011, 1'b0);
        for (int i = 0; i < FL; i++) step(1'b1, 4'b0110, 1'b0);
        idle(FL + 1);
        chk("b2b_po", rx_last, 4'b0110);

        // Load attempts while busy are ignored
        step(1'b1, 4'b1100, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b1, 4'b0011, 1'b0);
        step(1'b1, 4'b0011, 1'b0);
        idle(FL + 2);
        chk("ignore_po", rx_last, 4'b1100);

        // Reset mid-frame, then a fresh frame
        step(1'b1, 4'b1111, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b1, 4'b0101, 1'b0);
        idle(FL + 1);
        chk("post_rst_po", rx_last, 4'b0101);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 6, W'($urandom), $urandom_range(0, 49) == 0);
        end
        idle(FL + 2);
        chk("words_pending", word_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
